// File: rtl/debug_pkg.sv
// Shared types and constants for the debug dump controller.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        DUMP  = 2'd2,
        DRAIN = 2'd3
    } dump_state_e;

    localparam int DROP_CNT_W = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/debug_dump_fifo.sv
// Synchronous show-ahead FIFO with a registered head word and synchronous flush.
module debug_dump_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d, cnt_rem_s;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok_s, pop_ok_s;

    assign full      = (cnt_q == DEPTH_C);
    assign empty     = (cnt_q == '0);
    assign head      = head_q;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer/count next state and the word that becomes the next head.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_s);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_ok_s);
        cnt_rem_s = cnt_q - (PTR_W+1)'(pop_ok_s);
        cnt_d     = cnt_rem_s + (PTR_W+1)'(push_ok_s);
        head_d    = head_q;
        // When nothing else remains, the incoming word goes straight to the head.
        if (cnt_d == '0) begin
            head_d = head_q;
        end else if (cnt_rem_s == '0) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control state: pointers, count and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/debug_dump_ctrl.sv
// Debug dump controller: captures one full generator sweep from memory into a valid/ready stream.
// Optional macro DEBUG_DUMP_TAG_EN adds the m_addr source-address output.
module debug_dump_ctrl
    import debug_pkg::*;
#(
    parameter int LENGTH     = 12000,
    // One extra code so the generator's terminal value LENGTH is representable.
    parameter int ADDR_W     = $clog2(LENGTH + 1),
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     debug_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_last,
`ifdef DEBUG_DUMP_TAG_EN
    output logic [ADDR_W-1:0]     m_addr,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH - 1);
    localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(LENGTH);
`ifdef DEBUG_DUMP_TAG_EN
    localparam int FW = DATA_W + ADDR_W + 1;
`else
    localparam int FW = DATA_W + 1;
`endif

    dump_state_e           state_q, state_d;
    logic                  rd_issue_s, done_s, clr_stats_s;
    logic [RD_LAT-1:0]     pv_q, pl_q;
    logic                  overflow_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [FW-1:0]         push_word_s, head_s;
    logic                  fifo_full_s, fifo_empty_s;

    // Next state and read strobe; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        rd_issue_s  = 1'b0;
        done_s      = 1'b0;
        clr_stats_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ARM;
                    clr_stats_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (debug_addr == '0) begin
                    rd_issue_s = 1'b1;
                    state_d    = DUMP;
                end else begin
                    state_d = ARM;
                end
            end
            DUMP: begin
                rd_issue_s = (debug_addr < END_ADDR);
                if (debug_addr == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    state_d = DUMP;
                end
            end
            DRAIN: begin
                if (!(|pv_q) && fifo_empty_s) begin
                    state_d = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d     = IDLE;
            rd_issue_s  = 1'b0;
            done_s      = 1'b0;
            clr_stats_s = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Read-pipeline valid/last flags, aligned with mem_rd_data at the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
            pl_q <= '0;
        end else if (abort) begin
            pv_q <= '0;
            pl_q <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
            pv_q[0] <= rd_issue_s;
            pl_q[0] <= rd_issue_s && (debug_addr == LAST_ADDR);
        end
    end

`ifdef DEBUG_DUMP_TAG_EN
    logic [ADDR_W-1:0] pa_q [RD_LAT];

    // Source address travels alongside the valid/last flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) pa_q[i] <= pa_q[i-1];
            pa_q[0] <= debug_addr;
        end
    end

    assign push_word_s = {pa_q[RD_LAT-1], pl_q[RD_LAT-1], mem_rd_data};
    assign m_addr      = head_s[FW-1 -: ADDR_W];
`else
    assign push_word_s = {pl_q[RD_LAT-1], mem_rd_data};
`endif

    // Sticky drop statistics; a push into a full FIFO is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clr_stats_s) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (pv_q[RD_LAT-1] && fifo_full_s && !abort) begin
            overflow_q <= 1'b1;
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end else begin
            overflow_q <= overflow_q;
            drop_cnt_q <= drop_cnt_q;
        end
    end

    debug_dump_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (pv_q[RD_LAT-1]),
        .push_data (push_word_s),
        .pop       (m_ready),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign mem_rd_en   = rd_issue_s;
    assign mem_rd_addr = rd_issue_s ? debug_addr : '0;
    assign m_valid     = !fifo_empty_s;
    assign m_data      = head_s[DATA_W-1:0];
    assign m_last      = head_s[DATA_W] && !fifo_empty_s;
    assign busy        = (state_q != IDLE);
    assign done        = done_s;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Scoreboard bench: instance A (LENGTH=8, RD_LAT=1, depth 16), instance B (LENGTH=64, RD_LAT=2, depth 4).
module tb_debug_dump_ctrl;

    typedef struct { int addr; bit last; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // ---------------- instance A ----------------
    logic        a_start = 0, a_abort = 0, a_m_ready = 0;
    logic [3:0]  a_addr, a_rd_addr;
    logic        a_rd_en, a_m_valid, a_m_last, a_busy, a_done, a_ovf;
    logic [31:0] a_rdata, a_m_data;
    logic [15:0] a_drop;
`ifdef DEBUG_DUMP_TAG_EN
    logic [3:0]  a_m_addr;
`endif

    debug_dump_ctrl #(.LENGTH(8), .DATA_W(32), .RD_LAT(1), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .debug_addr(a_addr),
        .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rdata),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last),
`ifdef DEBUG_DUMP_TAG_EN
        .m_addr(a_m_addr),
`endif
        .busy(a_busy), .done(a_done), .overflow(a_ovf), .drop_cnt(a_drop));

    // ---------------- instance B ----------------
    logic        b_start = 0, b_abort = 0, b_m_ready = 0;
    logic [6:0]  b_addr, b_rd_addr;
    logic        b_rd_en, b_m_valid, b_m_last, b_busy, b_done, b_ovf;
    logic [31:0] b_m1, b_rdata, b_m_data;
    logic [15:0] b_drop;
`ifdef DEBUG_DUMP_TAG_EN
    logic [6:0]  b_m_addr;
`endif

    debug_dump_ctrl #(.LENGTH(64), .DATA_W(32), .RD_LAT(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .debug_addr(b_addr),
        .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rdata),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
`ifdef DEBUG_DUMP_TAG_EN
        .m_addr(b_m_addr),
`endif
        .busy(b_busy), .done(b_done), .overflow(b_ovf), .drop_cnt(b_drop));

    function automatic logic [31:0] f(input int a);
        return 32'hC0DE_0000 + (32'(a) * 32'd3);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Free-running generators and memory models.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_addr <= 4'd0;
            b_addr <= 7'd0;
        end else begin
            a_addr <= (a_addr == 4'd8)  ? 4'd0 : a_addr + 4'd1;
            b_addr <= (b_addr == 7'd64) ? 7'd0 : b_addr + 7'd1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_rd_en) a_rdata <= f(int'(a_rd_addr));
        if (b_rd_en) b_m1 <= f(int'(b_rd_addr));
        b_rdata <= b_m1;
    end

    // Scoreboards and monitor state.
    exp_t        a_q[$], b_q[$];
    int          a_done_n = 0, b_done_n = 0;
    bit          a_hold_v, b_hold_v, a_pend, b_pend;
    logic [32:0] a_hold, b_hold;
    int          a_t0, b_t0;

    // Monitor: compares transfers, stall stability, first-word latency; counts done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            a_hold_v = 0; b_hold_v = 0; a_pend = 0; b_pend = 0;
        end else begin
            if (a_done) a_done_n++;
            if (b_done) b_done_n++;
            if (a_rd_en && a_rd_addr == 4'd0) begin a_t0 = cyc; a_pend = 1; end
            if (b_rd_en && b_rd_addr == 7'd0) begin b_t0 = cyc; b_pend = 1; end
            if (a_pend && a_m_valid) begin chk("a_latency", 64'(cyc - a_t0), 64'd2); a_pend = 0; end
            if (b_pend && b_m_valid) begin chk("b_latency", 64'(cyc - b_t0), 64'd3); b_pend = 0; end
            if (a_hold_v && a_m_valid) chk("a_stall_stable", {a_m_last, a_m_data}, a_hold);
            if (b_hold_v && b_m_valid) chk("b_stall_stable", {b_m_last, b_m_data}, b_hold);
            a_hold_v = a_m_valid && !a_m_ready; a_hold = {a_m_last, a_m_data};
            b_hold_v = b_m_valid && !b_m_ready; b_hold = {b_m_last, b_m_data};
            if (a_m_valid && a_m_ready) begin
                if (a_q.size() == 0) chk("a_extra_word", 64'd1, 64'd0);
                else begin
                    e = a_q.pop_front();
                    chk("a_data", a_m_data, f(e.addr));
                    chk("a_last", a_m_last, e.last);
`ifdef DEBUG_DUMP_TAG_EN
                    chk("a_tag", a_m_addr, e.addr);
`endif
                end
            end
            if (b_m_valid && b_m_ready) begin
                if (b_q.size() == 0) chk("b_extra_word", 64'd1, 64'd0);
                else begin
                    e = b_q.pop_front();
                    chk("b_data", b_m_data, f(e.addr));
                    chk("b_last", b_m_last, e.last);
`ifdef DEBUG_DUMP_TAG_EN
                    chk("b_tag", b_m_addr, e.addr);
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_a(input int n, input int last_addr);
        for (int i = 0; i < n; i++) a_q.push_back('{i, (i == last_addr)});
    endtask

    task automatic push_b(input int n, input int last_addr);
        for (int i = 0; i < n; i++) b_q.push_back('{i, (i == last_addr)});
    endtask

    task automatic start_a();
        a_start = 1; tick(); a_start = 0;
    endtask

    task automatic start_b();
        b_start = 1; tick(); b_start = 0;
    endtask

    task automatic wait_a_idle(input bit toggle, input int budget);
        int n = 0;
        while (a_busy && n < budget) begin
            if (toggle) a_m_ready = ~a_m_ready;
            tick(); n++;
        end
        chk("a_idle_timeout", a_busy, 0);
    endtask

    task automatic wait_b_idle(input int budget);
        int n = 0;
        while (b_busy && n < budget) begin tick(); n++; end
        chk("b_idle_timeout", b_busy, 0);
    endtask

    initial begin
        int d0, n;
        #1 rst = 1;
        #3;
        chk("rst_a_outs", {a_m_valid, a_m_last, a_busy, a_done, a_ovf, a_rd_en}, 6'd0);
        chk("rst_a_data", a_m_data, 0);
        chk("rst_a_drop", a_drop, 0);
        chk("rst_b_outs", {b_m_valid, b_m_last, b_busy, b_done, b_ovf, b_rd_en}, 6'd0);
        tick(); tick();
        rst = 0;
        tick();

        // 1: start at addr 5, arm until 0, clean dump with m_ready high
        a_m_ready = 1;
        n = 0;
        while (a_addr != 4'd5 && n < 20) begin tick(); n++; end
        chk("t1_wait_addr5", a_addr, 5);
        d0 = a_done_n;
        push_a(8, 7);
        start_a();
        chk("t1_armed_busy", a_busy, 1);
        chk("t1_armed_no_read", a_rd_en, 0);
        wait_a_idle(0, 60);
        chk("t1_done_once", a_done_n - d0, 1);
        chk("t1_overflow", a_ovf, 0);
        chk("t1_queue_empty", a_q.size(), 0);

        // 3: m_ready toggling, all words in order, no drops
        d0 = a_done_n;
        push_a(8, 7);
        start_a();
        wait_a_idle(1, 80);
        a_m_ready = 1;
        chk("t3_done_once", a_done_n - d0, 1);
        chk("t3_drops", a_drop, 0);
        chk("t3_queue_empty", a_q.size(), 0);

        // 4: abort together with start at the 3rd read of the dump
        push_a(8, 7);
        start_a();
        n = 0;
        while (!(a_rd_en && a_rd_addr == 4'd2) && n < 40) begin tick(); n++; end
        chk("t4_reach_addr2", a_rd_addr, 2);
        d0 = a_done_n;
        a_abort = 1; a_start = 1;
        tick();
        a_abort = 0; a_start = 0;
        a_q.delete();
        chk("t4_idle_after_abort", a_busy, 0);
        chk("t4_mvalid_flushed", a_m_valid, 0);
        tick(); tick(); tick();
        chk("t4_still_empty", a_m_valid, 0);
        chk("t4_no_done", a_done_n - d0, 0);
        d0 = a_done_n;
        push_a(8, 7);
        start_a();
        wait_a_idle(0, 60);
        chk("t4_clean_done", a_done_n - d0, 1);
        chk("t4_queue_empty", a_q.size(), 0);

        // 2: depth-4 FIFO, sink stalled for the whole dump
        b_m_ready = 0;
        d0 = b_done_n;
        push_b(4, -1);
        start_b();
        n = 0;
        while (b_drop != 16'd60 && n < 300) begin tick(); n++; end
        tick(); tick(); tick();
        chk("t2_drop_cnt", b_drop, 60);
        chk("t2_overflow", b_ovf, 1);
        chk("t2_holding", {b_busy, b_m_valid}, 2'b11);
        chk("t2_no_done_yet", b_done_n - d0, 0);
        b_m_ready = 1;
        wait_b_idle(20);
        chk("t2_done_once", b_done_n - d0, 1);
        chk("t2_queue_empty", b_q.size(), 0);

        // 6: RD_LAT=2 clean dump; start clears stats; tags checked when enabled
        d0 = b_done_n;
        push_b(64, 63);
        start_b();
        chk("t6_stats_cleared", {b_ovf, b_drop}, 17'd0);
        wait_b_idle(200);
        chk("t6_done_once", b_done_n - d0, 1);
        chk("t6_no_drop", b_drop, 0);
        chk("t6_queue_empty", b_q.size(), 0);

        // 5: asynchronous reset while draining
        a_m_ready = 0;
        push_a(8, 7);
        start_a();
        n = 0;
        while (!(a_busy && a_addr == 4'd8 && a_m_valid) && n < 40) begin tick(); n++; end
        tick(); tick();
        chk("t5_in_drain", {a_busy, a_m_valid}, 2'b11);
        #1 rst = 1;
        #1;
        chk("t5_async_outs", {a_m_valid, a_m_last, a_busy, a_done, a_ovf, a_rd_en}, 6'd0);
        chk("t5_async_data", {a_m_data, a_drop}, 48'd0);
        a_q.delete();
        tick();
        rst = 0;
        tick();
        chk("t5_idle_after", a_busy, 0);
        a_m_ready = 1;
        d0 = a_done_n;
        push_a(8, 7);
        start_a();
        wait_a_idle(0, 60);
        chk("t5_clean_done", a_done_n - d0, 1);
        chk("t5_queue_empty", a_q.size(), 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
